// File: rtl/window_gen.sv
// 3x3 sliding-window generator: two line buffers plus a three-column shift window.
// Emits one strobe per window that lies fully inside the image.
module window_gen #(
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16,
  parameter int PIX_W      = 8,
  localparam int RW = $clog2(IMG_HEIGHT),
  localparam int CW = $clog2(IMG_WIDTH)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ena,
  input  logic               sof,
  input  logic               pix_valid,
  input  logic [PIX_W-1:0]   pix_in,
  output logic [9*PIX_W-1:0] win_out,
  output logic               win_valid,
  output logic [RW-1:0]      win_row,
  output logic [CW-1:0]      win_col,
  output logic               eof
);

  // Handshake: a pixel is consumed on every cycle with ena & pix_valid (no ready);
  // win_valid is a single-cycle strobe with no backpressure from the consumer.
  logic [PIX_W-1:0] lb0 [IMG_WIDTH];
  logic [PIX_W-1:0] lb1 [IMG_WIDTH];
  logic [PIX_W-1:0] win_q [9];
  logic [PIX_W-1:0] win_d [9];
  logic [RW-1:0]    row_cnt, cur_row;
  logic [CW-1:0]    col_cnt, cur_col;
  logic             accept, full, last_row, last_col;
  logic [PIX_W-1:0] top, mid;

  // sof forces the pixel accepted in the same cycle to be (0,0).
  always_comb begin
    accept   = ena & pix_valid;
    cur_row  = sof ? '0 : row_cnt;
    cur_col  = sof ? '0 : col_cnt;
    top      = lb0[cur_col];
    mid      = lb1[cur_col];
    last_row = (cur_row == RW'(IMG_HEIGHT - 1));
    last_col = (cur_col == CW'(IMG_WIDTH - 1));
    full     = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    for (int r = 0; r < 3; r++) begin
      win_d[3*r]     = win_q[3*r + 1];
      win_d[3*r + 1] = win_q[3*r + 2];
    end
    win_d[2] = top;
    win_d[5] = mid;
    win_d[8] = pix_in;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row_cnt   <= '0;
      col_cnt   <= '0;
      win_out   <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      eof       <= 1'b0;
      for (int i = 0; i < IMG_WIDTH; i++) begin
        lb0[i] <= '0;
        lb1[i] <= '0;
      end
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
    end else begin
      win_valid <= 1'b0;
      eof       <= 1'b0;
      if (ena) begin
        if (pix_valid) begin
          lb0[cur_col] <= mid;
          lb1[cur_col] <= pix_in;
          for (int k = 0; k < 9; k++) win_q[k] <= win_d[k];
          if (last_col) begin
            col_cnt <= '0;
            row_cnt <= last_row ? '0 : cur_row + RW'(1);
          end else begin
            col_cnt <= cur_col + CW'(1);
            row_cnt <= cur_row;
          end
          // Output register only loads complete windows; stale columns never reach it.
          if (full) begin
            win_valid <= 1'b1;
            win_row   <= cur_row - RW'(1);
            win_col   <= cur_col - CW'(1);
            eof       <= last_row & last_col;
            for (int k = 0; k < 9; k++) win_out[k*PIX_W +: PIX_W] <= win_d[k];
          end
        end else if (sof) begin
          row_cnt <= '0;
          col_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_gen.sv
// Bench for window_gen on a 4x4 image: frame-level reference model checked every
// cycle, plus literal window expectations for the directed scenarios.
module tb_window_gen;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          resetn, ena, sof, pix_valid;
  logic [PW-1:0] pix_in;
  logic [71:0]   win_out;
  logic          win_valid, eof;
  logic [1:0]    win_row, win_col;

  window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
    .clk(clk), .resetn(resetn), .ena(ena), .sof(sof), .pix_valid(pix_valid),
    .pix_in(pix_in), .win_out(win_out), .win_valid(win_valid), .win_row(win_row),
    .win_col(win_col), .eof(eof)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the image as a 2D array, windows read straight out of it.
  logic [PW-1:0] img [H][W];
  int            m_r, m_c, m_row, m_col;
  logic          m_valid, m_eof;
  logic [71:0]   m_win;
  bit            check_en = 1'b0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_r = 0; m_c = 0; m_row = 0; m_col = 0;
      m_valid = 1'b0; m_eof = 1'b0; m_win = '0;
    end else begin
      m_valid = 1'b0;
      m_eof   = 1'b0;
      if (ena) begin
        if (sof) begin m_r = 0; m_c = 0; end
        if (pix_valid) begin
          img[m_r][m_c] = pix_in;
          if (m_r >= 2 && m_c >= 2) begin
            m_valid = 1'b1;
            for (int k = 0; k < 9; k++) m_win[k*PW +: PW] = img[m_r-2+k/3][m_c-2+k%3];
            m_row = m_r - 1;
            m_col = m_c - 1;
            m_eof = (m_r == H-1) && (m_c == W-1);
          end
          m_c++;
          if (m_c == W) begin
            m_c = 0;
            m_r = (m_r == H-1) ? 0 : m_r + 1;
          end
        end
      end
    end
  end

  // Strobe log for the directed checks
  logic [71:0] log_win[$];
  int          log_rc[$];
  logic        log_eof[$];

  always @(negedge clk) begin
    if (check_en) begin
      chk("win_valid", 72'(win_valid), 72'(m_valid));
      chk("eof", 72'(eof), 72'(m_eof));
      chk("win_out", win_out, m_win);
      chk("win_row", 72'(win_row), 72'(m_row));
      chk("win_col", 72'(win_col), 72'(m_col));
    end
    if (resetn && win_valid) begin
      log_win.push_back(win_out);
      log_rc.push_back(int'(win_row) * 10 + int'(win_col));
      log_eof.push_back(eof);
    end
  end

  // Driver
  task automatic drive(input logic [PW-1:0] p, input logic s, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        ena       = 1'($urandom_range(0, 1));
        pix_valid = ena ? 1'b0 : 1'($urandom_range(0, 1));
        sof       = ena ? 1'b0 : 1'($urandom_range(0, 1));
        pix_in    = PW'($urandom);
      end
    end
    @(negedge clk);
    ena = 1'b1; pix_valid = 1'b1; sof = s; pix_in = p;
    @(posedge clk);
    #1;
    pix_valid = 1'b0; sof = 1'b0; pix_in = PW'($urandom);
  endtask

  task automatic stream(input int base, input int first, input int count, input bit with_sof,
                        input bit gaps);
    for (int i = first; i < first + count; i++)
      drive(PW'(i % 16 + 1 + base), with_sof && (i == first), gaps);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [71:0] lit_win(input int cr, input int cc, input int base);
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[k*PW +: PW] = PW'(4 * (cr - 1 + k/3) + (cc - 1 + k%3) + 1 + base);
    return w;
  endfunction

  // Scoreboard for one frame's four windows against literal expectations
  task automatic check_frame(input string tag, input int base);
    logic [71:0] exp_q[$];
    int          exp_rc[$];
    for (int r = 1; r <= 2; r++)
      for (int c = 1; c <= 2; c++) begin
        exp_q.push_back(lit_win(r, c, base));
        exp_rc.push_back(r * 10 + c);
      end
    for (int i = 0; i < 4; i++) begin
      if (log_win.size() == 0) begin
        chk({tag, "_missing_strobe"}, 72'(i), 72'(4));
        return;
      end
      chk({tag, "_win"}, log_win.pop_front(), exp_q.pop_front());
      chk({tag, "_centre"}, 72'(log_rc.pop_front()), 72'(exp_rc.pop_front()));
      chk({tag, "_eof"}, 72'(log_eof.pop_front()), 72'(i == 3));
    end
  endtask

  task automatic clear_logs();
    log_win.delete(); log_rc.delete(); log_eof.delete();
  endtask

  initial begin
    resetn = 1'b0; ena = 1'b0; sof = 1'b0; pix_valid = 1'b0; pix_in = '0;
    #1;
    chk("reset_win_out", win_out, 72'd0);
    chk("reset_win_valid", 72'(win_valid), 72'd0);
    chk("reset_rowcol", 72'({win_row, win_col}), 72'd0);
    chk("reset_eof", 72'(eof), 72'd0);
    repeat (2) @(negedge clk);
    resetn   = 1'b1;
    check_en = 1'b1;

    // 1: back-to-back frame, first strobe the cycle after pixel 11
    clear_logs();
    stream(0, 0, 10, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_no_early_strobe", 72'(log_win.size()), 72'd0);
    stream(0, 10, 1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("t1_first_strobe_timing", 72'(win_valid), 72'd1);
    chk("t1_first_window_lit", win_out, 72'h0b0a09070605030201);
    stream(0, 11, 5, 1'b0, 1'b0);
    settle();
    // 2: all four windows of the frame
    chk("t2_strobe_count", 72'(log_win.size()), 72'd4);
    chk("t2_last_window_lit", log_win[log_win.size()-1], 72'h100f0e0c0b0a080706);
    check_frame("t2", 0);

    // 3: random ena/pix_valid gaps
    clear_logs();
    stream(0, 0, 16, 1'b1, 1'b1);
    settle();
    chk("t3_strobe_count", 72'(log_win.size()), 72'd4);
    check_frame("t3", 0);

    // 4: sof mid-frame restarts at (0,0)
    clear_logs();
    stream(0, 0, 7, 1'b1, 1'b0);
    stream(32, 0, 16, 1'b1, 1'b0);
    settle();
    chk("t4_strobe_count", 72'(log_win.size()), 72'd4);
    chk("t4_first_window_lit", log_win[0], 72'h2b2a29272625232221);
    check_frame("t4", 32);

    // 5: asynchronous reset mid-frame
    clear_logs();
    stream(0, 0, 12, 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_pre_reset_valid_window", 72'(win_out != 0), 72'd1);
    #2 resetn = 1'b0;
    #1;
    chk("t5_async_win_out", win_out, 72'd0);
    chk("t5_async_rowcol", 72'({win_row, win_col}), 72'd0);
    chk("t5_async_valid_eof", 72'({win_valid, eof}), 72'd0);
    @(negedge clk);
    resetn = 1'b1;
    clear_logs();
    stream(0, 0, 16, 1'b0, 1'b0);
    settle();
    chk("t5_strobe_count", 72'(log_win.size()), 72'd4);
    check_frame("t5", 0);

    // 6: two frames back-to-back
    clear_logs();
    stream(0, 0, 16, 1'b1, 1'b0);
    stream(16, 0, 16, 1'b0, 1'b0);
    settle();
    chk("t6_strobe_count", 72'(log_win.size()), 72'd8);
    check_frame("t6a", 0);
    check_frame("t6b", 16);

    // randomized frames with random pixel data against the model
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < W * H; i++) drive(PW'($urandom), (i == 0), 1'b1);
    end
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
